data_gen_mc: RTL and testbench
==============================

# data_gen_mc

Parametrised multi-channel stimulus generator for clocked verification benches. It produces NCH independent WIDTH-bit data lanes, generated as pseudo-random (Galois LFSR), incrementing or constant. Lanes are delivered in bursts of programmable length over a valid/ready handshake. A one-cycle-delayed copy of the bus gives checkers a pre-edge sampled view without clocking-block skew.

## Interface

- WIDTH, 4, bits per lane (≥2)
- NCH, 2, number of lanes (1–16)
- POLY, 4'hC, Galois LFSR feedback mask (WIDTH bits), default x^4+x^3+1, period 15
- clk  in  1  rising-edge clock (single clock domain)
- rst  in  1  synchronous reset, active-high
- start  in  1  burst request, sampled in IDLE only
- mode  in  2  0 = LFSR, 1 = increment, 2 = constant, 3 = treated as LFSR
- len  in  8  beats per burst; 0 means 256
- seed  in  WIDTH  base seed
- ready  in  1  downstream accept
- valid  out  1  data valid
- data  out  NCH*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
- data_smp  out  NCH*WIDTH  `data` as it was one cycle earlier
- beat_cnt  out  8  beats accepted in current burst
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the last beat is accepted

## Operation

- Two states: IDLE and RUN.
- IDLE, start = 1:
  - latch mode and len.
  - Load lane i with (seed + i) mod 2^WIDTH. In LFSR mode, a lane that loads 0 is forced to 1.
  - Go to RUN with valid = 1 and beat_cnt = 0.
- RUN, beat accepted (valid & ready):
  - beat_cnt increments.
  - Every lane advances:
    - LFSR: s = s[0] ? (s>>1)^POLY : s>>1.
    - Increment: s = s+1, wrapping mod 2^WIDTH.
    - Constant: s unchanged.
- RUN, last beat accepted (the len-th, or 256th when len = 0): next state IDLE, valid = 0, done = 1 for one cycle. beat_cnt holds its final value until the next start.
- RUN, valid & !ready: data, valid and beat_cnt hold unchanged. No lane advance.
- start in RUN is ignored. This includes start coincident with the last handshake.
- mode, len and seed changes during RUN have no effect.
- data_smp loads `data` every cycle, unconditionally.

## Timing

- Reset (rst = 1 at an edge): next cycle state = IDLE and every output is 0 (valid, data, data_smp, beat_cnt, busy, done). Reset wins over start and over any handshake in the same cycle. Reset mid-burst abandons the burst with no done pulse.
- Latency from start: start sampled at edge N gives valid = 1, busy = 1 and the first data after edge N.
- Throughput: with ready held high, one beat per cycle. A burst of L beats occupies L cycles of valid.
- done rises in the cycle after the final accepting edge, coincident with valid = 0 and busy = 0.
- Back-to-back bursts: start may be asserted during the done cycle. The next burst's valid rises one cycle later, giving a minimum 1-cycle valid gap.
- data_smp equals data delayed by exactly one edge. After reset it is 0 for one cycle before tracking data.
- beat_cnt is 8 bits. For len = 0 it wraps to 0 on the 256th beat, which is also the last beat.

## Test plan

- Reset check: rst high 3 cycles, ready = 1, start = 1 → all outputs 0, valid never rises; after release, valid rises on the next cycle.
- LFSR burst: mode 0, seed 1, len 5, ready = 1, WIDTH 4, NCH 2 →
  - lane0 = 1, C, 6, 3, D;
  - lane1 = 2, 1, C, 6, 3;
  - done pulses once, one cycle after the 5th beat;
  - beat_cnt ends at 5.
- Increment wrap: mode 1, seed E, len 4 → lane0 = E, F, 0, 1; lane1 = F, 0, 1, 2.
- Zero-seed guard: mode 0, seed 0 → lane0 first value 1 (forced), lane1 first value 1; subsequent values follow the LFSR.
- Backpressure: mode 1, seed 0, len 3, ready pattern 1,0,0,1,1 → data 0,1,1,1,2 across those cycles; done after the 5th cycle; data_smp lags data by one cycle throughout.
- Abort and overlap:
  - Reset asserted at beat 2 of a len-10 burst → outputs 0 next cycle, no done.
  - Separately, start held high for a whole len-2 burst → the second burst's valid rises exactly 2 cycles after the first burst's last beat is accepted.

Source files
------------

// File: rtl/data_gen_mc.sv
// Multi-lane burst stimulus generator (LFSR / increment / constant); first beat valid one cycle after start.
// Under backpressure (valid & !ready) data, valid and beat_cnt hold and no lane advances.
module data_gen_mc #(
  parameter int               WIDTH = 4,
  parameter int               NCH   = 2,
  parameter logic [WIDTH-1:0] POLY  = 4'hC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [7:0]           len,
  input  logic [WIDTH-1:0]     seed,
  input  logic                 ready,
  output logic                 valid,
  output logic [NCH*WIDTH-1:0] data,
  output logic [NCH*WIDTH-1:0] data_smp,
  output logic [7:0]           beat_cnt,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [1:0]           mode_q;
  logic [7:0]           len_q;
  logic [NCH*WIDTH-1:0] load_dat;
  logic [NCH*WIDTH-1:0] adv_dat;
  logic                 last_beat;

  function automatic logic is_lfsr(input logic [1:0] m);
    return (m == 2'd0) || (m == 2'd3);
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s, input logic [1:0] m);
    logic [WIDTH-1:0] r;
    case (m)
      2'd1:    r = s + WIDTH'(1);
      2'd2:    r = s;
      default: r = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endcase
    return r;
  endfunction

  always_comb begin
    load_dat = '0;
    adv_dat  = '0;
    for (int i = 0; i < NCH; i++) begin
      logic [WIDTH-1:0] lane;
      lane = seed + WIDTH'(i);
      // An all-zero LFSR state would lock up, so it is nudged to 1.
      if (is_lfsr(mode) && (lane == '0)) lane = WIDTH'(1);
      load_dat[i*WIDTH +: WIDTH] = lane;
      adv_dat[i*WIDTH +: WIDTH]  = advance(data[i*WIDTH +: WIDTH], mode_q);
    end
  end

  // len = 0 means 256 beats: the 8-bit count wraps to 0 on exactly that beat.
  assign last_beat = ((beat_cnt + 8'd1) == len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= '0;
      len_q    <= '0;
      valid    <= 1'b0;
      data     <= '0;
      data_smp <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      data_smp <= data;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q   <= mode;
            len_q    <= len;
            data     <= load_dat;
            valid    <= 1'b1;
            busy     <= 1'b1;
            beat_cnt <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (ready) begin
            beat_cnt <= beat_cnt + 8'd1;
            data     <= adv_dat;
            if (last_beat) begin
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_gen_mc.sv
// Directed bench for data_gen_mc (WIDTH 4, NCH 2, POLY 4'hC); outputs sampled 1 time unit after each rising edge.
module tb_data_gen_mc;

  logic       clk = 1'b0;
  logic       rst, start, ready;
  logic [1:0] mode;
  logic [7:0] len;
  logic [3:0] seed;
  logic       valid, busy, done;
  logic [7:0] data, data_smp, beat_cnt;

  int vectors = 0;
  int miscompares = 0;

  data_gen_mc #(.WIDTH(4), .NCH(2), .POLY(4'hC)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len), .seed(seed),
    .ready(ready), .valid(valid), .data(data), .data_smp(data_smp),
    .beat_cnt(beat_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_lfsr [5];
    logic [7:0] exp_inc  [4];
    logic [7:0] exp_bp   [5];
    logic       rdy_bp   [5];
    exp_lfsr = '{8'h21, 8'h1C, 8'hC6, 8'h63, 8'h3D};
    exp_inc  = '{8'hFE, 8'h0F, 8'h10, 8'h21};
    exp_bp   = '{8'h10, 8'h21, 8'h21, 8'h21, 8'h32};
    rdy_bp   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset held with start and ready asserted: everything stays zero.
    rst = 1'b1; start = 1'b1; ready = 1'b1; mode = 2'd0; seed = 4'h1; len = 8'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outputs", {valid, busy, done, beat_cnt, data, data_smp}, 32'h0);
    end

    // LFSR burst, seed 1, len 5; start still high at release.
    rst = 1'b0;
    tick();
    start = 1'b0;
    check("lfsr_busy", busy, 1'b1);
    check("lfsr_smp_first", data_smp, 8'h00);
    for (int i = 0; i < 5; i++) begin
      check("lfsr_valid", valid, 1'b1);
      check("lfsr_data", data, exp_lfsr[i]);
      check("lfsr_cnt", beat_cnt, 8'(i));
      if (i > 0) check("lfsr_smp", data_smp, exp_lfsr[i-1]);
      check("lfsr_no_done", done, 1'b0);
      tick();
    end
    check("lfsr_done_flags", {done, valid, busy}, 3'b100);
    check("lfsr_cnt_final", beat_cnt, 8'd5);
    tick();
    check("lfsr_done_once", done, 1'b0);
    check("lfsr_cnt_hold", beat_cnt, 8'd5);

    // Increment with wrap; configuration changes mid-burst must be ignored.
    mode = 2'd1; seed = 4'hE; len = 8'd4; start = 1'b1;
    tick();
    start = 1'b0; mode = 2'd0; seed = 4'h5; len = 8'd1;
    for (int i = 0; i < 4; i++) begin
      check("inc_data", data, exp_inc[i]);
      check("inc_valid", valid, 1'b1);
      tick();
    end
    check("inc_done", {done, valid, beat_cnt}, {1'b1, 1'b0, 8'd4});

    // Zero-seed guard in LFSR mode.
    mode = 2'd0; seed = 4'h0; len = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("zseed_first", data, 8'h11);
    tick();
    check("zseed_second", data, 8'hCC);
    tick();
    check("zseed_done", {done, valid}, 2'b10);

    // Backpressure: ready 1,0,0,1,1 over a len-3 increment burst.
    mode = 2'd1; seed = 4'h0; len = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ready = rdy_bp[i];
      check("bp_data", data, exp_bp[i]);
      check("bp_valid", valid, 1'b1);
      if (i > 0) check("bp_smp", data_smp, exp_bp[i-1]);
      tick();
    end
    check("bp_done", {done, valid, beat_cnt}, {1'b1, 1'b0, 8'd3});
    ready = 1'b1;

    // Reset mid-burst at beat 2 of a len-10 burst: no done afterwards.
    len = 8'd10; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort_cnt_before", beat_cnt, 8'd2);
    rst = 1'b1;
    tick();
    check("abort_outputs", {valid, busy, done, beat_cnt, data, data_smp}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_done", {done, valid}, 2'b00);
    end

    // Start held high through a len-2 burst: back-to-back with a 1-cycle gap.
    len = 8'd2; start = 1'b1;
    tick();
    check("ovl_first", {valid, data}, {1'b1, 8'h10});
    tick();
    check("ovl_second_no_reload", {valid, beat_cnt, data}, {1'b1, 8'd1, 8'h21});
    tick();
    check("ovl_gap", {done, valid, busy}, 3'b100);
    tick();
    start = 1'b0;
    check("ovl_restart", {valid, busy, beat_cnt, data}, {1'b1, 1'b1, 8'd0, 8'h10});
    tick();
    tick();
    check("ovl_done2", {done, beat_cnt}, {1'b1, 8'd2});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
